// File: rtl/crc_top_core.sv
// PCIe DLL LCRC generator: sequence-prefix capture, unrolled CRC-32 network, {TLP, LCRC} output.
// Build option CRC_PIPE_EN adds a register after the CRC network (2-cycle latency).

module crc_byte_lane #(
    parameter int               CRC_W = 32,
    parameter logic [CRC_W-1:0] POLY  = 32'h04C11DB7
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);
    logic [CRC_W-1:0] c;

    // Byte bit 0 enters first; the final bit-reversal in crc_lfsr turns this into the zlib value.
    always_comb begin
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            c = {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{c[CRC_W-1] ^ data[b]}} & POLY);
        end
        crc_out = c;
    end
endmodule

module crc_lfsr #(
    parameter int DATA_W = 112,
    parameter int CRC_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);
    localparam int NUM_LANES = DATA_W / 8;

    logic [CRC_W-1:0] chain [NUM_LANES+1];

    assign chain[0] = '1;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        crc_byte_lane #(.CRC_W(CRC_W)) u_lane (
            .crc_in  (chain[i]),
            .data    (data[DATA_W-1-8*i -: 8]),
            .crc_out (chain[i+1])
        );
    end

    always_comb begin
        crc = '0;
        for (int k = 0; k < CRC_W; k++) begin
            crc[k] = ~chain[NUM_LANES][CRC_W-1-k];
        end
    end
endmodule

module crc_seq_prefix #(
    parameter int TLP_W = 96,
    parameter int SEQ_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [TLP_W-1:0] tlp_in,
    output logic [TLP_W+15:0] stage_q
);
    logic [SEQ_W-1:0] seq_q;

    // The pre-increment sequence number goes into the prefix; wraps modulo 2^SEQ_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q   <= '0;
            stage_q <= '0;
        end else if (we) begin
            stage_q <= {{(16-SEQ_W){1'b0}}, seq_q, tlp_in};
            seq_q   <= seq_q + SEQ_W'(1);
        end
    end
endmodule

module crc_out_asm #(
    parameter int TLP_W  = 96,
    parameter int CRC_W  = 32,
    parameter int STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STAGES:1]        ld,
    input  logic [TLP_W-1:0]       tlp,
    input  logic [CRC_W-1:0]       lcrc,
    output logic [TLP_W+CRC_W-1:0] crc_o
);
    logic [TLP_W+CRC_W-1:0] word;

    assign word = {tlp, lcrc};

`ifdef CRC_PIPE_EN
    logic [TLP_W+CRC_W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            crc_o  <= '0;
        end else begin
            if (ld[1])      pipe_q <= word;
            if (ld[STAGES]) crc_o  <= pipe_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            crc_o <= '0;
        else if (ld[STAGES]) crc_o <= word;
    end
`endif
endmodule

module crc_top_core #(
    parameter int TLP_W = 96,
    parameter int SEQ_W = 12,
    parameter int CRC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [TLP_W-1:0]       tlp_in,
    output logic [TLP_W+CRC_W-1:0] crc_o
);
`ifdef CRC_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam int STG_W = TLP_W + 16;

    logic [STAGES:0]  vld_pipe;
    logic [STAGES:1]  vld_q;
    logic [STG_W-1:0] stage_q;
    logic [CRC_W-1:0] lcrc;

    // Holding crc_o on idle cycles relies on these valids, not on the data path.
    assign vld_pipe = {vld_q, we};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_pipe[STAGES-1:0];
    end

    crc_seq_prefix #(.TLP_W(TLP_W), .SEQ_W(SEQ_W)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .tlp_in  (tlp_in),
        .stage_q (stage_q)
    );

    crc_lfsr #(.DATA_W(STG_W), .CRC_W(CRC_W)) u_lfsr (
        .data (stage_q),
        .crc  (lcrc)
    );

    crc_out_asm #(.TLP_W(TLP_W), .CRC_W(CRC_W), .STAGES(STAGES)) u_out (
        .clk   (clk),
        .rst   (rst),
        .ld    (vld_pipe[STAGES:1]),
        .tlp   (stage_q[TLP_W-1:0]),
        .lcrc  (lcrc),
        .crc_o (crc_o)
    );
endmodule

// File: tb/tb_crc_top_core.sv
// Bench for crc_top_core: vector table, hand sequences and random traffic against a zlib-style model.
// Latency expectation follows CRC_PIPE_EN.

module tb_crc_top_core;
`ifdef CRC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [95:0]  tlp_in;
    logic [127:0] crc_o;

    crc_top_core dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .tlp_in (tlp_in),
        .crc_o  (crc_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; logic [127:0] d; } slot_t;
    typedef struct { string nm; logic [95:0] tlp; logic [127:0] exp; } vec_t;

    logic [31:0]  crc_tab [256];
    slot_t        hist[$];
    logic [11:0]  seq_m;
    logic [127:0] exp_o;
    int           n_tot = 0;
    int           n_pass = 0;

    function automatic void build_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    // Byte-table CRC-32 over seqhi, seqlo, TLP byte0..11.
    function automatic logic [31:0] model_lcrc(input logic [11:0] s, input logic [95:0] t);
        logic [7:0]  bytes [14];
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        bytes[0] = {4'h0, s[11:8]};
        bytes[1] = s[7:0];
        for (int i = 0; i < 12; i++) bytes[i+2] = t[95-8*i -: 8];
        for (int i = 0; i < 14; i++) c = crc_tab[c[7:0] ^ bytes[i]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, req);
    endtask

    task automatic rst_model();
        hist.delete();
        seq_m = '0;
        exp_o = '0;
    endtask

    // One clock with the given inputs; the model result for capture e appears after edge e+LAT.
    task automatic cyc(input bit w, input logic [95:0] t);
        we = w;
        tlp_in = t;
        @(posedge clk);
        #1;
        hist.push_back('{v: w, d: {t, model_lcrc(seq_m, t)}});
        if (w) seq_m = seq_m + 12'd1;
        if (hist.size() > LAT) begin
            slot_t s;
            s = hist.pop_front();
            if (s.v) exp_o = s.d;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        we = 1'b0;
        rst_model();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", crc_o, 128'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t        vtab [5];
        logic [95:0] ta;
        logic [31:0] l0, l1, first_l, last_l;

        build_tab();
        ta = 96'h123456789abcdefffff12345;
        l0 = '0; l1 = '0; first_l = '0; last_l = '0;
        vtab[0] = '{"tlp_a_seq0", ta, {ta, model_lcrc(12'd0, ta)}};
        vtab[1] = '{"tlp_a_seq1", ta, {ta, model_lcrc(12'd1, ta)}};
        vtab[2] = '{"zeros_seq2", 96'h0, {96'h0, model_lcrc(12'd2, 96'h0)}};
        vtab[3] = '{"ones_seq3", {96{1'b1}}, {{96{1'b1}}, model_lcrc(12'd3, {96{1'b1}})}};
        vtab[4] = '{"a5_seq4", {12{8'hA5}}, {{12{8'hA5}}, model_lcrc(12'd4, {12{8'hA5}})}};

        tlp_in = '0;
        apply_reset();
        repeat (3) begin
            cyc(1'b0, rnd96());
            chk("idle_no_capture", crc_o, 128'h0);
        end

        for (int i = 0; i < 5 + LAT; i++) begin
            if (i < 5) cyc(1'b1, vtab[i].tlp);
            else       cyc(1'b0, rnd96());
            if (i >= LAT) begin
                chk(vtab[i-LAT].nm, crc_o, vtab[i-LAT].exp);
                if (i - LAT == 0) l0 = crc_o[31:0];
                if (i - LAT == 1) l1 = crc_o[31:0];
            end
        end
        n_tot++;
        if (l0 != l1) n_pass++;
        else $display("FAIL seq_differ: seq0 lcrc %h seq1 lcrc %h should differ", l0, l1);
        repeat (3) begin
            cyc(1'b0, rnd96());
            chk("hold_idle", crc_o, vtab[4].exp);
        end

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), rnd96());
            chk("rand", crc_o, exp_o);
        end

        apply_reset();
        for (int k = 0; k < 4097 + LAT; k++) begin
            cyc(k < 4097, ta);
            chk("wrap_stream", crc_o, exp_o);
            if (k - LAT == 0)    first_l = crc_o[31:0];
            if (k - LAT == 4096) last_l  = crc_o[31:0];
        end
        chk("wrap_seq0_again", {96'h0, last_l}, {96'h0, first_l});
        chk("wrap_first_seq0", {96'h0, first_l}, {96'h0, vtab[0].exp[31:0]});

        // Reset lands between the capture edge of ta and its output edge.
        cyc(1'b1, rnd96());
        cyc(1'b1, ta);
        #3 rst = 1'b0;
        rst_model();
        #1 chk("rst_async_clear", crc_o, 128'h0);
        we = 1'b0;
        @(posedge clk);
        #1 chk("rst_hold", crc_o, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 1 + LAT; k++) begin
            cyc(k == 0, ta);
            chk("post_rst_stream", crc_o, exp_o);
        end
        chk("seq0_after_rst", crc_o, vtab[0].exp);

        for (int i = 0; i < 100; i++) begin
            cyc(1'($urandom_range(0, 1)), rnd96());
            chk("rand_post_rst", crc_o, exp_o);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
